imm_narrow_32to28: RTL and testbench

// - Inverse of the 28->32 immediate sign extension: packs a 32-bit signed value into a
//   28-bit immediate/jump-target field and flags values that do not fit in 28 bits.
// - Sits in the assembler/encode path and the branch-target write-back path, ahead of the

---
 rtl/imm_narrow_32to28.sv | 102 ++++++++++
 tb/tb_imm_narrow_32to28.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_narrow_32to28.sv
// Narrows a signed IN_W value to an OUT_W immediate field with overflow flag, behind a 2-entry skid stage.
// Optional build macro IMM_NARROW_SATURATE_EN clamps overflowing values instead of truncating them.
module imm_narrow_32to28 #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 28,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int HI_W = IN_W - OUT_W + 1;

  logic [HI_W-1:0]  w_upper;
  logic             w_fits;
  logic             w_ovf;
  logic             w_sign;
  logic [OUT_W-1:0] w_narrow;
  logic             w_accept;
  logic             w_outFree;

  logic             r_outValid;
  logic [OUT_W-1:0] r_outData;
  logic             r_outOvf;
  logic             r_skidValid;
  logic [OUT_W-1:0] r_skidData;
  logic             r_skidOvf;
  logic [CNT_W-1:0] r_count;

  // The value fits when every bit from the MSB down to the field's sign bit agrees.
  assign w_upper = in_data[IN_W-1:OUT_W-1];
  assign w_fits  = (&w_upper) | ~(|w_upper);
  assign w_ovf   = ~w_fits;
  assign w_sign  = in_data[IN_W-1];

`ifdef IMM_NARROW_SATURATE_EN
  assign w_narrow = w_ovf ? (w_sign ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}})
                          : in_data[OUT_W-1:0];
`else
  assign w_narrow = in_data[OUT_W-1:0];
`endif

  assign w_accept  = in_valid & ~r_skidValid;
  assign w_outFree = ~r_outValid | out_ready;

  // The skid entry always has priority over new input so ordering is preserved;
  // new input is never accepted while the skid entry is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outOvf    <= 1'b0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_skidOvf   <= 1'b0;
    end else if (w_outFree) begin
      if (r_skidValid) begin
        r_outValid  <= 1'b1;
        r_outData   <= r_skidData;
        r_outOvf    <= r_skidOvf;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_outValid <= 1'b1;
        r_outData  <= w_narrow;
        r_outOvf   <= w_ovf;
      end else begin
        r_outValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidValid <= 1'b1;
      r_skidData  <= w_narrow;
      r_skidOvf   <= w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if (w_accept && w_ovf && !(&r_count)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign in_ready  = ~r_skidValid;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ovf   = r_outOvf;
  assign ovf_count = r_count;

endmodule

// File: tb/tb_imm_narrow_32to28.sv
// Self-checking bench for imm_narrow_32to28: directed vector table, handshake corner sequences,
// and randomized traffic scored against a range-based reference model.
module tb_imm_narrow_32to28;

  typedef struct {
    logic [31:0] inData;
    logic [27:0] expData;
    logic        expOvf;
  } vecT;

`ifdef IMM_NARROW_SATURATE_EN
  localparam logic [27:0] OVF_POS_EXP = 28'h7FFFFFF;
  localparam logic [27:0] OVF_NEG_EXP = 28'h8000000;
`else
  localparam logic [27:0] OVF_POS_EXP = 28'h8000000;
  localparam logic [27:0] OVF_NEG_EXP = 28'h7FFFFFF;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic        out_ovf;
  logic        clr_count;
  logic [15:0] ovf_count;

  int testsRun = 0;
  int testsFailed = 0;

  vecT expQ[$];
  vecT vecs[6];
  int  modelCount = 0;
  logic        prevStall = 1'b0;
  logic [27:0] prevData = '0;
  logic        prevOvf = 1'b0;

  imm_narrow_32to28 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a value is representable iff it lies in the signed 28-bit range.
  function automatic vecT refModel(input logic [31:0] v);
    vecT    r;
    longint s;
    s = longint'($signed(v));
    r.inData = v;
    r.expOvf = (s > 134217727) || (s < -134217728);
    if (!r.expOvf) begin
      r.expData = v[27:0];
    end else begin
`ifdef IMM_NARROW_SATURATE_EN
      r.expData = (s < 0) ? 28'h8000000 : 28'h7FFFFFF;
`else
      r.expData = v[27:0];
`endif
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  function automatic logic [31:0] randData();
    logic [31:0] x;
    logic [31:0] edges[8];
    edges = '{32'h07FFFFFF, 32'h08000000, 32'hF8000000, 32'hF7FFFFFF,
              32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    x = $urandom;
    case ($urandom_range(0, 3))
      0: return x;
      1: return {{4{x[27]}}, x[27:0]};
      2: return edges[$urandom_range(0, 7)];
      default: return {{8{x[23]}}, x[23:0]} ^ 32'h0800_0000;
    endcase
  endfunction

  // Scoreboard, stall-stability and counter model, sampled mid-cycle.
  always @(negedge clk) begin
    vecT e;
    vecT n;
    if (!rst_n) begin
      expQ.delete();
      prevStall  = 1'b0;
      modelCount = 0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(prevData));
        checkOutput("stall_ovf", 32'(out_ovf), 32'(prevOvf));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_data", 32'(out_data), 32'(e.expData));
          checkOutput("sb_ovf", 32'(out_ovf), 32'(e.expOvf));
          if (!out_ovf) checkOutput("sext_roundtrip", {{4{out_data[27]}}, out_data}, e.inData);
        end
      end
      if (clr_count) begin
        modelCount = 0;
        if (in_valid && in_ready) expQ.push_back(refModel(in_data));
      end else if (in_valid && in_ready) begin
        n = refModel(in_data);
        expQ.push_back(n);
        if (n.expOvf && modelCount < 65535) modelCount++;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevOvf   = out_ovf;
    end
  end

  initial begin
    vecs[0] = '{32'h07FFFFFF, 28'h7FFFFFF, 1'b0};
    vecs[1] = '{32'hF8000000, 28'h8000000, 1'b0};
    vecs[2] = '{32'h00000000, 28'h0000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 28'hFFFFFFF, 1'b0};
    vecs[4] = '{32'h08000000, OVF_POS_EXP, 1'b1};
    vecs[5] = '{32'hF7FFFFFF, OVF_NEG_EXP, 1'b1};

    rst_n     = 1'b0;
    clr_count = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("rst_count", 32'(ovf_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back table, one output per cycle with 1-cycle latency.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].inData, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("tbl_valid", 32'(out_valid), 32'd1);
      checkOutput("tbl_data", 32'(out_data), 32'(vecs[i].expData));
      checkOutput("tbl_ovf", 32'(out_ovf), 32'(vecs[i].expOvf));
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("tbl_end_valid", 32'(out_valid), 32'd0);
    checkOutput("tbl_count", 32'(ovf_count), 32'd2);

    // Backpressure: two accepted, then in_ready drops until the consumer drains.
    applyStimulus(1'b1, 32'h00000011, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_a_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_a_data", 32'(out_data), 32'h11);
    checkOutput("bp_a_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 32'h00000022, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_b_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_b_data", 32'(out_data), 32'h11);
    applyStimulus(1'b1, 32'h00000033, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("bp_c_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_c_data", 32'(out_data), 32'h11);
    end
    applyStimulus(1'b1, 32'h00000033, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp_rel_b", 32'(out_data), 32'h22);
    checkOutput("bp_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_rel_c", 32'(out_data), 32'h33);
    applyStimulus(1'b1, 32'hFFFFFF44, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp_rel_d", 32'(out_data), 32'hFFFFF44);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp_done_valid", 32'(out_valid), 32'd0);

    // Reset with both entries full discards them and clears the counter at once.
    applyStimulus(1'b1, 32'h10000000, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h90000000, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_count", 32'(ovf_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("mrst_idle_valid", 32'(out_valid), 32'd0);
    end

    // Counter saturation, then clear colliding with an overflow accept.
    applyStimulus(1'b1, 32'h40000000, 1'b1);
    repeat (65537) @(posedge clk);
    #1;
    checkOutput("cnt_sat", 32'(ovf_count), 32'hFFFF);
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cnt_clr_prio", 32'(ovf_count), 32'd0);
    clr_count = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cnt_after_clr", 32'(ovf_count), 32'd1);

    for (int c = 0; c < 10000; c++) begin
      applyStimulus($urandom_range(0, 9) != 0, randData(), $urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    checkOutput("rand_count", 32'(ovf_count), 32'(modelCount));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
